// File: rtl/alu_arbiter_if.sv
// Bundle for two requesters, the shared ALU and the response port
// of alu_arbiter.
interface alu_arbiter_if #(
  parameter int DATA_W = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [1:0]        req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        req1_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_negative;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;
  logic              rsp_negative;
  logic              busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_carry, alu_zero,
    input  alu_negative, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_result,
    output rsp_carry, rsp_zero, rsp_negative,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_carry, alu_zero,
    output alu_negative, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_result,
    input  rsp_carry, rsp_zero, rsp_negative,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 5
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [1:0] op_q, op_d;
  logic id_q, id_d;
  logic rid_q, rid_d;
  logic lg_q, lg_d;
  logic busy_q, busy_d;
  logic rv_q, rv_d;
  logic c_q, c_d;
  logic z_q, z_d;
  logic n_q, n_d;
  logic any_v, both_v, gnt, accept;

  assign any_v  = bus.req0_valid | bus.req1_valid;
  assign both_v = bus.req0_valid & bus.req1_valid;

`ifdef ALU_ARB_RR_EN
  assign gnt = both_v ? ~lg_q : bus.req1_valid;
`else
  assign gnt = ~bus.req0_valid;
`endif

  assign accept = (state_q == IDLE) & any_v & ~rst;
  assign bus.req0_ready = accept & ~gnt;
  assign bus.req1_ready = accept & gnt;

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_op       = op_q;
  assign bus.rsp_valid    = rv_q;
  assign bus.rsp_id       = rid_q;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_carry    = c_q;
  assign bus.rsp_zero     = z_q;
  assign bus.rsp_negative = n_q;
  assign bus.busy         = busy_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    lg_d    = lg_q;
    rid_d   = rid_q;
    res_d   = res_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (any_v) begin
          a_d     = gnt ? bus.req1_a : bus.req0_a;
          b_d     = gnt ? bus.req1_b : bus.req0_b;
          op_d    = gnt ? bus.req1_op : bus.req0_op;
          id_d    = gnt;
          lg_d    = gnt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_result;
        c_d     = bus.alu_carry;
        z_d     = bus.alu_zero;
        n_d     = bus.alu_negative;
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    rv_d   = (state_d == RESP);
  end

  // Reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      lg_q    <= 1'b1;
      rid_q   <= 1'b0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      lg_q    <= lg_d;
      rid_q   <= rid_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
    end
  end
endmodule
